// File: rtl/uart_pkg.sv
// Shared UART definitions used by the word transmitter and the matching receiver.
// Holds the transmitter state encoding, frame geometry and the default baud divisor.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // 100 MHz system clock at 9600 baud
    localparam int UART_CLKS_PER_BIT = 10416;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter for the UART transmitter: counts 0..CLKS_PER_BIT-1 while running
// and flags the final cycle of every serial bit with bit_end.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_end = run && (count == LAST_COUNT);

    // Wrapping at bit_end makes every bit boundary a restart, so bit levels never drift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (restart || bit_end) begin
            count <= '0;
        end else if (run) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: accepts one word per valid/ready handshake and sends it
// as BYTES_PER_WORD back-to-back 8N1 frames, least significant byte and bit first.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = UART_CLKS_PER_BIT,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [8*BYTES_PER_WORD-1:0]   word_in,
    input  logic                          word_valid,
    output logic                          word_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          byte_done,
    output logic                          word_done
);

    localparam int WORD_W     = UART_DATA_BITS * BYTES_PER_WORD;
    localparam int BIT_IDX_W  = $clog2(UART_DATA_BITS);
    localparam int BYTE_IDX_W = $clog2(BYTES_PER_WORD) + 1;
    localparam logic [BIT_IDX_W-1:0]  LAST_BIT  = BIT_IDX_W'(UART_DATA_BITS - 1);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_word_tx: CLKS_PER_BIT must be at least 2");
    end
    if (BYTES_PER_WORD < 1) begin : g_bad_bytes_per_word
        $error("uart_word_tx: BYTES_PER_WORD must be at least 1");
    end
    if (UART_FRAME_BITS != UART_DATA_BITS + 2) begin : g_bad_frame
        $error("uart_word_tx: frame must be start + data + one stop bit");
    end

    tx_state_t               state, state_n;
    logic [WORD_W-1:0]       shreg, shreg_n;
    logic [BIT_IDX_W-1:0]    bit_idx, bit_idx_n, next_bit;
    logic [BYTE_IDX_W-1:0]   byte_idx, byte_idx_n;
    logic [UART_DATA_BITS-1:0] cur_byte;
    logic                    tx_n, busy_n, ready_n;
    logic                    accept, run, bit_end;

    assign accept   = word_valid && word_ready;
    assign run      = (state != IDLE);
    assign cur_byte = shreg[UART_DATA_BITS-1:0];
    assign next_bit = bit_idx + BIT_IDX_W'(1);

    assign byte_done = (state == STOP) && bit_end;
    assign word_done = byte_done && (byte_idx == LAST_BYTE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .run     (run),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            word_ready <= 1'b1;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_idx    <= bit_idx_n;
            byte_idx   <= byte_idx_n;
            tx         <= tx_n;
            busy       <= busy_n;
            word_ready <= ready_n;
        end
    end

    // tx is computed one level ahead so the registered line changes exactly on bit edges
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        tx_n       = tx;
        busy_n     = busy;
        ready_n    = word_ready;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    shreg_n    = word_in;
                    byte_idx_n = '0;
                    state_n    = START;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                    ready_n    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_BIT) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = next_bit;
                        tx_n      = cur_byte[next_bit];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx < LAST_BYTE) begin
                        byte_idx_n = byte_idx + BYTE_IDX_W'(1);
                        shreg_n    = shreg >> UART_DATA_BITS;
                        state_n    = START;
                        tx_n       = 1'b0;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        ready_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
Serial transmitter that drives the line into the UART peripheral's rx pin.
- Accepts one 32-bit word per valid/ready handshake.
- Sends it as four 8N1 frames, byte 0 (bits [7:0]) first, each byte LSB-first.
- Used as the remote-end stimulus source in UART bring-up harnesses, and as the host-side transmitter when the core talks to an external UART.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per serial bit (100 MHz / 9600 baud); legal range 2..65535.
- BYTES_PER_WORD, 4, bytes sent per accepted word; word width = 8*BYTES_PER_WORD.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- word_in  in  32  word to transmit; sampled only at acceptance
- word_valid  in  1  word_in is valid
- word_ready  out  1  block can accept a word (IDLE only)
- tx  out  1  serial output, idles high
- busy  out  1  high from acceptance until the final stop bit ends
- byte_done  out  1  one-cycle pulse at the end of each stop bit
- word_done  out  1  one-cycle pulse at the end of the last stop bit of the word

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, word_ready=1, busy=0, byte_done=0, word_done=0.
  - State IDLE; counters and shift register cleared.
  - Applies immediately, including mid-frame. tx returns high without completing the frame.
- States: IDLE, START, DATA, STOP.
- Acceptance: at a rising edge with word_valid=1 and word_ready=1.
  - word_in is latched into the shift register.
  - byte index = 0, state = START.
  - tx, busy and word_ready are registered, so they change at that same edge: tx=0, busy=1, word_ready=0.
- Bit timing: a cycle counter runs from 0 to CLKS_PER_BIT-1. Each bit level holds for exactly CLKS_PER_BIT cycles. No fractional baud.
- START: tx=0 for one bit time, then DATA with bit index = 0.
- DATA: tx = current byte bit[index], LSB first. After bit 7 completes, go to STOP.
- STOP: tx=1 for one bit time. On its final cycle:
  - byte_done=1.
  - If byte index < BYTES_PER_WORD-1: byte index +1, shift register moves right by 8, go directly to START with no idle gap.
  - Else: word_done=1 on the same cycle as byte_done, then IDLE.
- Return to IDLE: word_ready=1 and busy=0 are registered at the edge that enters IDLE.
  - A word held valid is accepted at the next edge.
  - Back-to-back words therefore have one idle-high clock between the last stop bit and the next start bit.
- Word duration: exactly 10*BYTES_PER_WORD*CLKS_PER_BIT cycles from the acceptance edge to the IDLE-entry edge.
- word_valid while busy: ignored, no queuing. word_in changes after acceptance have no effect.
- Counter widths: the bit-time counter is sized by $clog2(CLKS_PER_BIT). The byte index is sized by $clog2(BYTES_PER_WORD)+1. No wrap is possible inside legal ranges.
- Parameter check: CLKS_PER_BIT < 2 is a static elaboration error.

Decomposition:
- Shared package uart_pkg:
  - the tx state enum (IDLE/START/DATA/STOP);
  - UART_DATA_BITS=8;
  - UART_FRAME_BITS=10;
  - default CLKS_PER_BIT constant, shared with the receiver.
- One natural sub-module, uart_baud_gen:
  - the bit-time counter;
  - restarted on acceptance and on every bit boundary;
  - outputs a bit_end pulse on its final count.
- All other logic stays inline.

Test Plan:
1. Reset values: hold rst=0, toggle word_valid -> tx=1, word_ready=1, busy=0, no pulses. Release rst -> outputs unchanged.
2. Single word 0x000000FA, CLKS_PER_BIT=4, BYTES_PER_WORD=4:
   - byte 0 on tx: 0,0,1,0,1,1,1,1,1,1, each level 4 cycles;
   - bytes 1–3 are 0x00 frames;
   - busy lasts 160 cycles;
   - word_done fires once, coincident with the 4th byte_done.
3. Back-to-back: word_valid held high with 0x11223344 then 0xA5A5A5A5 -> bytes 44,33,22,11,A5,A5,A5,A5; exactly one idle-high clock between the words.
4. valid while busy: pulse word_valid with 0xDEADBEEF mid-frame -> ignored, the original word completes intact, word_ready stays 0.
5. Reset mid-operation: assert rst during DATA of byte 2 -> tx=1 and busy=0 immediately (asynchronous). After release a new word 0x0000005A transmits from byte 0 correctly.
6. Loopback: feed tx into the UART rx with matching CLKS_PER_BIT and send 0x000000FA -> the receiver's captured data_out byte equals 0xFA with no framing error.
